// File: rtl/regfile_wb_arb_pkg.sv
// regfile_wb_arb_pkg
//   Shared definitions for the register-file write-port controller:
//   controller state encoding and helpers that derive the register count
//   and the zero-fill counter width from LG_DEPTH.
package regfile_wb_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Number of registers for a given log2 depth.
   function automatic int unsigned depth_of(input int unsigned lg_depth);
      return 32'd1 << lg_depth;
   endfunction

   // Fill counter needs one extra bit so it can count up to DEPTH itself.
   function automatic int unsigned fill_cnt_width(input int unsigned lg_depth);
      return lg_depth + 32'd1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. With a single requester it grants that
//   requester; with both it grants the one not granted most recently.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     req[1:0]   : request vector (bit 0 = wb0, bit 1 = wb1)
//     advance    : grant is being used this cycle; priority pointer may move
//     gnt[1:0]   : one-hot (or zero) combinational grant
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // 1 when requester 1 was granted most recently. Resets to 1 so that
   // the first contended cycle favours requester 0.
   logic last_was1;

   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_was1 ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_was1 <= 1'b1;
      end else if (advance && (gnt != '0)) begin
         last_was1 <= gnt[1];
      end
   end

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
//   Write-port controller for a 2R/1W register-file RAM. After reset it
//   zero-fills every register, then arbitrates the single write port
//   between two writeback requesters (wb0: ALU, wb1: load/long-latency)
//   with valid/ready handshakes and round-robin priority.
//   Optional feature macro: REGFILE_WB_BYPASS_EN -- when defined, a write
//   presented in the same cycle as a read of the same address is forwarded
//   to the read data returned one cycle later.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     wbK_valid/addr/data        : writeback request K (K = 0, 1)
//     wbK_ready                  : request K accepted when valid & ready
//     wr_en/wr_addr/wr_data      : registered RAM write port
//     rd_addr0/1                 : read addresses as driven to the RAM
//     ram_rd_data0/1             : raw RAM read data (one cycle after addr)
//     rd_data0/1                 : read data to the pipeline
//     init_done                  : high once zero-fill has completed
module regfile_wb_arb
   import regfile_wb_arb_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned LG_DEPTH      = 5,
   parameter bit          HARDWIRE_ZERO = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wb0_valid,
   input  logic [LG_DEPTH-1:0] wb0_addr,
   input  logic [WIDTH-1:0]    wb0_data,
   output logic                wb0_ready,
   input  logic                wb1_valid,
   input  logic [LG_DEPTH-1:0] wb1_addr,
   input  logic [WIDTH-1:0]    wb1_data,
   output logic                wb1_ready,
   output logic                wr_en,
   output logic [LG_DEPTH-1:0] wr_addr,
   output logic [WIDTH-1:0]    wr_data,
   input  logic [LG_DEPTH-1:0] rd_addr0,
   input  logic [LG_DEPTH-1:0] rd_addr1,
   input  logic [WIDTH-1:0]    ram_rd_data0,
   input  logic [WIDTH-1:0]    ram_rd_data1,
   output logic [WIDTH-1:0]    rd_data0,
   output logic [WIDTH-1:0]    rd_data1,
   output logic                init_done
);

   localparam int unsigned DEPTH = depth_of(LG_DEPTH);
   localparam int unsigned CNT_W = fill_cnt_width(LG_DEPTH);
   localparam logic [CNT_W-1:0] FILL_END = CNT_W'(DEPTH);

   state_t              state;
   logic [CNT_W-1:0]    fill_cnt;
   logic                run_active;
   logic [1:0]          gnt;
   logic                accept;
   logic [LG_DEPTH-1:0] sel_addr;
   logic [WIDTH-1:0]    sel_data;
   logic                drop_write;

   // Grants are only honoured in RUN and never while reset is asserted.
   assign run_active = (state == ST_RUN) && !reset;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({wb1_valid, wb0_valid}),
      .advance (run_active),
      .gnt     (gnt)
   );

   assign wb0_ready = run_active && gnt[0];
   assign wb1_ready = run_active && gnt[1];

   always_comb begin
      accept     = wb0_ready || wb1_ready;
      sel_addr   = wb1_ready ? wb1_addr : wb0_addr;
      sel_data   = wb1_ready ? wb1_data : wb0_data;
      drop_write = HARDWIRE_ZERO && (sel_addr == '0);
   end

   // Fill presents counter values 0..DEPTH-1; the cycle after the last
   // one is spent switching to RUN, so init_done and ready first appear
   // in the cycle following the presentation of DEPTH-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_INIT;
         fill_cnt  <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (fill_cnt == FILL_END) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
                  wr_en     <= 1'b0;
               end else begin
                  wr_en    <= 1'b1;
                  wr_addr  <= fill_cnt[LG_DEPTH-1:0];
                  wr_data  <= '0;
                  fill_cnt <= fill_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (accept) begin
                  wr_en   <= !drop_write;
                  wr_addr <= sel_addr;
                  wr_data <= sel_data;
               end else begin
                  wr_en <= 1'b0;
               end
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   logic [LG_DEPTH-1:0] rd_addr0_q;
   logic [LG_DEPTH-1:0] rd_addr1_q;
   logic                byp_en;
   logic [LG_DEPTH-1:0] byp_addr;
   logic [WIDTH-1:0]    byp_data;

   // Capture the read addresses and the write presented to the RAM in the
   // same cycle; the RAM returns old data for that collision, so the
   // captured write data is substituted when the read data comes back.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr0_q <= '0;
         rd_addr1_q <= '0;
         byp_en     <= 1'b0;
         byp_addr   <= '0;
         byp_data   <= '0;
      end else begin
         rd_addr0_q <= rd_addr0;
         rd_addr1_q <= rd_addr1;
         byp_en     <= wr_en;
         byp_addr   <= wr_addr;
         byp_data   <= wr_data;
      end
   end

   always_comb begin
      rd_data0 = '0;
      rd_data1 = '0;
      if (!reset) begin
         rd_data0 = (byp_en && (rd_addr0_q == byp_addr)) ? byp_data : ram_rd_data0;
         rd_data1 = (byp_en && (rd_addr1_q == byp_addr)) ? byp_data : ram_rd_data1;
      end
   end
`else
   // Read addresses are only needed by the bypass path.
   logic rd_addr_unused;
   assign rd_addr_unused = ^{rd_addr0, rd_addr1};

   always_comb begin
      rd_data0 = reset ? '0 : ram_rd_data0;
      rd_data1 = reset ? '0 : ram_rd_data1;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

   localparam int unsigned W  = 32;
   localparam int unsigned LG = 5;
   localparam int          DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          wb0_valid, wb1_valid;
   logic [LG-1:0] wb0_addr, wb1_addr;
   logic [W-1:0]  wb0_data, wb1_data;
   logic          wb0_ready, wb1_ready;
   logic          wr_en;
   logic [LG-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [LG-1:0] rd_addr0, rd_addr1;
   logic [W-1:0]  ram_rd_data0, ram_rd_data1;
   logic [W-1:0]  rd_data0, rd_data1;
   logic          init_done;

   always #5 clk = ~clk;

   regfile_wb_arb #(
      .WIDTH         (W),
      .LG_DEPTH      (LG),
      .HARDWIRE_ZERO (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wb0_valid    (wb0_valid),
      .wb0_addr     (wb0_addr),
      .wb0_data     (wb0_data),
      .wb0_ready    (wb0_ready),
      .wb1_valid    (wb1_valid),
      .wb1_addr     (wb1_addr),
      .wb1_data     (wb1_data),
      .wb1_ready    (wb1_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_addr0     (rd_addr0),
      .rd_addr1     (rd_addr1),
      .ram_rd_data0 (ram_rd_data0),
      .ram_rd_data1 (ram_rd_data1),
      .rd_data0     (rd_data0),
      .rd_data1     (rd_data1),
      .init_done    (init_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          v0;
      logic [LG-1:0] a0;
      logic [W-1:0]  d0;
      logic          v1;
      logic [LG-1:0] a1;
      logic [W-1:0]  d1;
      logic          r0;
      logic          r1;
   } vec_t;

   typedef struct {
      logic          en;
      logic [LG-1:0] addr;
      logic [W-1:0]  data;
   } wr_t;

   vec_t vecs[13];
   wr_t  sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full zero-fill from address 0, then the RUN-entry cycle.
   task automatic fill_check(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         check({tag, " fill wr_en"}, wr_en, 1);
         check({tag, " fill wr_addr"}, wr_addr, i);
         check({tag, " fill wr_data"}, wr_data, 0);
         check({tag, " fill init_done"}, init_done, 0);
         check({tag, " fill wb0_ready"}, wb0_ready, 0);
         check({tag, " fill wb1_ready"}, wb1_ready, 0);
         if (i == DEPTH - 1) begin
            wb0_valid = 1'b0;
            wb1_valid = 1'b0;
         end
      end
      tick();
      check({tag, " init_done rise"}, init_done, 1);
      check({tag, " post-fill wr_en"}, wr_en, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      wr_t e;
      logic [W-1:0] exp_byp;

      // valid, addr, data for wb0 / wb1, expected ready0 / ready1
      vecs[0]  = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,    1'b1, 1'b0};
      vecs[1]  = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,    1'b0, 1'b1};
      vecs[2]  = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,    1'b1, 1'b0};
      vecs[3]  = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,    1'b0, 1'b1};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 1'b0};
      vecs[5]  = '{1'b1, 5'd5,  32'h55,   1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
      vecs[6]  = '{1'b1, 5'd6,  32'h66,   1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
      vecs[7]  = '{1'b1, 5'd8,  32'h88,   1'b1, 5'd9,  32'h99,   1'b0, 1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hDEAD, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 5'd10, 32'h10,   1'b1, 5'd11, 32'h11,   1'b1, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'hC,    1'b0, 1'b1};
      vecs[11] = '{1'b1, 5'd0,  32'h77,   1'b0, 5'd0,  32'h0,    1'b1, 1'b0};
      vecs[12] = '{1'b1, 5'd1,  32'h1,    1'b1, 5'd2,  32'h2,    1'b0, 1'b1};

      reset = 1'b1;
      wb0_valid = 1'b1; wb0_addr = '0; wb0_data = '0;
      wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      ram_rd_data0 = 32'h5A5A; ram_rd_data1 = 32'hA5A5;

      repeat (3) begin
         tick();
         check("reset wr_en", wr_en, 0);
         check("reset wr_addr", wr_addr, 0);
         check("reset wr_data", wr_data, 0);
         check("reset init_done", init_done, 0);
         check("reset wb0_ready", wb0_ready, 0);
         check("reset rd_data0", rd_data0, 0);
         check("reset rd_data1", rd_data1, 0);
      end

      // Requests held during fill must not be granted.
      reset = 1'b0;
      wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'hA;
      wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'hB;
      fill_check("first");
      check("first post-fill wr_addr hold", wr_addr, DEPTH - 1);

      // Arbitration table with scoreboarded RAM writes.
      for (int k = 0; k < 13; k++) begin
         wb0_valid = vecs[k].v0; wb0_addr = vecs[k].a0; wb0_data = vecs[k].d0;
         wb1_valid = vecs[k].v1; wb1_addr = vecs[k].a1; wb1_data = vecs[k].d1;
         #1;
         check($sformatf("vec%0d wb0_ready", k), wb0_ready, vecs[k].r0);
         check($sformatf("vec%0d wb1_ready", k), wb1_ready, vecs[k].r1);
         if (vecs[k].r0)
            sb.push_back('{(vecs[k].a0 != 0), vecs[k].a0, vecs[k].d0});
         else if (vecs[k].r1)
            sb.push_back('{(vecs[k].a1 != 0), vecs[k].a1, vecs[k].d1});
         else
            sb.push_back('{1'b0, '0, '0});
         tick();
         if (sb.size() == 0) begin
            check($sformatf("vec%0d scoreboard empty", k), 1, 0);
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d wr_en", k), wr_en, e.en);
            if (e.en) begin
               check($sformatf("vec%0d wr_addr", k), wr_addr, e.addr);
               check($sformatf("vec%0d wr_data", k), wr_data, e.data);
            end
         end
      end

      // Reset in RUN while a write is presented: it must be discarded.
      reset = 1'b1;
      wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h5;
      wb1_valid = 1'b0;
      #1;
      check("run reset wb0_ready", wb0_ready, 0);
      tick();
      check("run reset wr_en", wr_en, 0);
      check("run reset init_done", init_done, 0);
      wb0_valid = 1'b0;
      reset = 1'b0;

      // Reset when the fill counter has reached 10.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("partial fill wr_addr", wr_addr, i);
      end
      reset = 1'b1;
      tick();
      check("mid-fill reset wr_en", wr_en, 0);
      check("mid-fill reset init_done", init_done, 0);
      reset = 1'b0;
      fill_check("refill");

      // Same-cycle write/read collision on address 7.
      wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1234;
      #1;
      check("bypass wb0_ready", wb0_ready, 1);
      tick();
      wb0_valid = 1'b0;
      check("bypass wr_en", wr_en, 1);
      check("bypass wr_addr", wr_addr, 7);
      check("bypass wr_data", wr_data, 32'h1234);
      rd_addr0 = 5'd7;
      rd_addr1 = 5'd8;
      tick();
      ram_rd_data0 = 32'h1111;
      ram_rd_data1 = 32'h2222;
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      exp_byp = 32'h1234;
`else
      exp_byp = 32'h1111;
`endif
      check("collision rd_data0", rd_data0, exp_byp);
      check("no-match rd_data1", rd_data1, 32'h2222);
      tick();
      ram_rd_data0 = 32'h3333;
      #1;
      check("after-write rd_data0", rd_data0, 32'h3333);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-port controller for the two-read/one-write register-file RAM. It zero-fills the array after reset, then shares the single write port between two writeback requesters (wb0: ALU, wb1: load/long-latency) with valid/ready handshakes and round-robin priority. It also provides optional same-cycle write-to-read bypass for both read ports. The block sits between the writeback stage and the register-file RAM.

## Interface
- WIDTH, 32, data width of one register
- LG_DEPTH, 5, log2 of register count (DEPTH = 2^LG_DEPTH)
- HARDWIRE_ZERO, 1, when 1, accepted writes to address 0 are dropped (handshake completes, no RAM write)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wb0_valid / wb1_valid  in  1  writeback request
- wb0_addr / wb1_addr  in  LG_DEPTH  destination register
- wb0_data / wb1_data  in  WIDTH  write data
- wb0_ready / wb1_ready  out  1  request accepted this cycle when valid & ready
- wr_en  out  1  RAM write enable (registered)
- wr_addr  out  LG_DEPTH  RAM write address (registered)
- wr_data  out  WIDTH  RAM write data (registered)
- rd_addr0 / rd_addr1  in  LG_DEPTH  read addresses as driven to the RAM
- ram_rd_data0 / ram_rd_data1  in  WIDTH  raw RAM read data
- rd_data0 / rd_data1  out  WIDTH  read data to the pipeline
- init_done  out  1  high once zero-fill is complete

## Operation
- FSM states: INIT, RUN. Reset forces INIT with fill counter = 0.
- INIT: each cycle presents wr_en=1, wr_addr=counter, wr_data=0, then increments the counter. After the cycle presenting DEPTH-1, the FSM moves to RUN. Both ready outputs stay 0.
- RUN: ready is computed combinationally from valid and the priority pointer.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted most recently is granted, and the pointer flips to the winner.
  - Neither valid: no grant, and the pointer holds.
- Ready for a requester is asserted only when that requester is granted. ready never depends on the requester's own valid beyond the grant.
- Accepted request: the registered wr_en/wr_addr/wr_data are loaded from it on that edge.
- No accept: wr_en=0 next cycle; wr_addr and wr_data hold.
- HARDWIRE_ZERO=1 and accepted addr==0: the handshake completes and the pointer updates, but wr_en=0.
- Reset mid-INIT or mid-RUN: the FSM returns to INIT and the counter clears. Any in-flight registered write is discarded (wr_en=0 on the cycle after reset is sampled). The zero-fill restarts from address 0.
- RAM read contract: data appears one cycle after rd_addr. A write presented in the same cycle as a read to the same address returns old data.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, init_done=0, wb0_ready=0, wb1_ready=0, priority pointer favours wb0, rd_data0/1 = 0 while reset is high.
- First edge with reset low: wr_en=1, wr_addr=0.
- Zero-fill takes exactly DEPTH consecutive wr_en cycles.
- init_done and ready can first be 1 in the cycle after wr_addr=DEPTH-1 is presented.
- Handshake-to-RAM-write latency is 1 cycle. Sustained throughput is one write per cycle.
- A requester held off by contention waits at most 1 cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - rd_addr0/1 and a copy of the presented write (wr_en, wr_addr, wr_data) are registered each cycle.
  - rd_dataK = registered write data when the registered read address equals the registered write address and the registered wr_en is 1. Otherwise rd_dataK = ram_rd_dataK.
  - This makes a same-cycle write visible to the read that returns one cycle later.
- Undefined: rd_dataK = ram_rd_dataK combinationally, with no added registers.

## Structure
- Shared package holds the INIT/RUN state enum and the DEPTH-derived constants.
- One sub-module: rr_arb2, a two-way round-robin arbiter containing the priority pointer, with inputs req[1:0] and advance and output gnt[1:0].
- Fill counter, FSM, write registers and bypass logic live in regfile_wb_arb.

## Test plan
- Reset held 3 cycles, then released with LG_DEPTH=5 → wr_en high for exactly 32 cycles with addresses 0..31 and data 0. init_done rises on cycle 33. No ready during fill.
- In RUN, both requesters valid every cycle (wb0 addr 3 data 0xA, wb1 addr 4 data 0xB) → grants alternate wb0, wb1, wb0, … and wr_en stays high with the matching addr/data one cycle after each accept.
- HARDWIRE_ZERO=1, wb1 writes addr 0 data 0xDEAD → wb1_ready=1, wr_en=0 next cycle, RAM unchanged.
- Reset asserted while the fill counter is at 10 → wr_en=0 the cycle after reset; after release the fill restarts at address 0 and init_done=0 throughout.
- With REGFILE_WB_BYPASS_EN, write presented to addr 7 data 0x1234 in the same cycle rd_addr0=7 → rd_data0=0x1234 the next cycle, even though the RAM returns the old value. Without the macro → the old RAM value is returned.
